// File: rtl/module_switches_pkg.sv
// Shared types and constants for the switch-input block.
package module_switches_pkg;

  // Capture handshake states
  typedef enum logic [1:0] {
    IDLE,
    VALID,
    RELEASE
  } estado_t;

  // 10 ms at 27 MHz
  localparam int DEBOUNCE_DEFAULT = 270000;

endpackage : module_switches_pkg

// File: rtl/module_debounce.sv
// Two-flop synchronizer followed by a vector debouncer.
// The W bits are debounced together: any bit change restarts the count,
// so the stable output only ever moves to a word held intact for
// DEBOUNCE_CYCLES+1 synchronized samples.
module module_debounce
  import module_switches_pkg::*;
#(
  parameter int W               = 1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     sync_a;
  logic [W-1:0]     sync_b;
  logic [W-1:0]     cand;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous input into the clk domain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= din;
      sync_b <= sync_a;
    end
  end

  // Track the candidate value and how long it has held; commit once it saturates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else if (sync_b != cand) begin
      cand <= sync_b;
      cnt  <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= cand;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : module_debounce

// File: rtl/module_switches.sv
// DIP-switch / load-button input block.
// Debounces the switch word and the load button, exports the live switch
// value, and on each debounced press offers one captured word through a
// valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for a debounced press
// VALID   | captured word offered, waiting for datos_ready
// RELEASE | word delivered, waiting for the button to be let go
module module_switches
  import module_switches_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_load,
  output logic [3:0] datos_in,
  output logic       datos_valid,
  input  logic       datos_ready,
  output logic [3:0] sw_vivo
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("module_switches: DEBOUNCE_CYCLES must be at least 2");
  end

  logic    btn_stable;
  logic    captura;
  estado_t estado;
  estado_t estado_next;

  module_debounce #(
    .W               (4),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_sw (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (sw),
    .stable (sw_vivo)
  );

  module_debounce #(
    .W               (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (btn_load),
    .stable (btn_stable)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado <= IDLE;
    end else begin
      estado <= estado_next;
    end
  end

  // Next-state logic; a release seen while VALID is not remembered, RELEASE re-checks it
  always_comb begin
    estado_next = estado;
    captura     = 1'b0;
    case (estado)
      IDLE: begin
        if (btn_stable) begin
          estado_next = VALID;
          captura     = 1'b1;
        end
      end
      VALID: begin
        if (datos_ready) begin
          estado_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!btn_stable) begin
          estado_next = IDLE;
        end
      end
      default: begin
        estado_next = IDLE;
      end
    endcase
  end

  // Output registers: word latched on capture only, valid follows the coming state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      datos_in    <= '0;
      datos_valid <= 1'b0;
    end else begin
      datos_valid <= (estado_next == VALID);
      if (captura) begin
        datos_in <= sw_vivo;
      end
    end
  end

endmodule : module_switches

// File: tb/tb_module_switches.sv
// Bench for module_switches with a short debounce window.
module tb_module_switches;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn_load;
  logic [3:0] datos_in;
  logic       datos_valid;
  logic       datos_ready;
  logic [3:0] sw_vivo;

  int total = 0;
  int bad   = 0;

  module_switches #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .btn_load    (btn_load),
    .datos_in    (datos_in),
    .datos_valid (datos_valid),
    .datos_ready (datos_ready),
    .sw_vivo     (sw_vivo)
  );

  always #5 clk = ~clk;

  // Transfers actually seen on the DUT interface
  int         dut_xfers = 0;
  logic [3:0] last_word = 4'h0;
  always @(posedge clk) begin
    if (rst_n && datos_valid && datos_ready) begin
      dut_xfers = dut_xfers + 1;
      last_word = datos_in;
    end
  end

  // Reference model: run lengths of synchronized samples, plus a pending-word flag
  logic [3:0] m_sw_d1, m_sw_d2, m_sw_last, m_sw_stable;
  logic       m_b_d1, m_b_d2, m_b_last, m_b_stable;
  int         m_sw_run, m_b_run;
  logic       m_valid, m_wait_rel;
  logic [3:0] m_word;
  int         m_xfers = 0;

  function automatic void model_edge();
    if (!rst_n) begin
      m_sw_d1 = 0; m_sw_d2 = 0; m_sw_last = 0; m_sw_stable = 0; m_sw_run = 1;
      m_b_d1 = 0;  m_b_d2 = 0;  m_b_last = 0;  m_b_stable = 0;  m_b_run = 1;
      m_valid = 0; m_wait_rel = 0; m_word = 0;
    end else begin
      if (m_valid) begin
        if (datos_ready) begin
          m_valid = 0; m_wait_rel = 1; m_xfers++;
        end
      end else if (m_wait_rel) begin
        if (!m_b_stable) m_wait_rel = 0;
      end else if (m_b_stable) begin
        m_valid = 1; m_word = m_sw_stable;
      end
      if (m_sw_d2 == m_sw_last) m_sw_run++;
      else begin m_sw_last = m_sw_d2; m_sw_run = 1; end
      if (m_sw_run > DC) m_sw_stable = m_sw_last;
      if (m_b_d2 == m_b_last) m_b_run++;
      else begin m_b_last = m_b_d2; m_b_run = 1; end
      if (m_b_run > DC) m_b_stable = m_b_last;
      m_sw_d2 = m_sw_d1; m_sw_d1 = sw;
      m_b_d2 = m_b_d1;   m_b_d1 = btn_load;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 0; sw = 4'b1010; btn_load = 0; datos_ready = 0;
    repeat (3) tick();
    total++; if (datos_in !== 4'h0) begin bad++; $display("FAIL reset_datos_in got=%h want=0", datos_in); end
    total++; if (datos_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", datos_valid); end
    total++; if (sw_vivo !== 4'h0) begin bad++; $display("FAIL reset_sw_vivo got=%h want=0", sw_vivo); end
    rst_n = 1;
    n = 0;
    for (int i = 0; i < 20 && sw_vivo !== 4'b1010; i++) begin
      tick(); n++;
    end
    total++; if (n != 7) begin bad++; $display("FAIL reset_latency got=%0d want=7 edges", n); end
    total++; if (sw_vivo !== m_sw_stable) begin bad++; $display("FAIL reset_model sw_vivo got=%h want=%h", sw_vivo, m_sw_stable); end
  endtask

  task automatic test_glitch();
    sw = 4'b0000;
    repeat (12) tick();
    total++; if (sw_vivo !== 4'b0000) begin bad++; $display("FAIL glitch_settle got=%h want=0", sw_vivo); end
    sw = 4'b0101;
    repeat (3) tick();
    sw = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      tick();
      total++; if (sw_vivo !== 4'b0000) begin bad++; $display("FAIL glitch_hold cyc=%0d got=%h want=0", i, sw_vivo); end
    end
  endtask

  task automatic test_capture();
    int x0;
    sw = 4'b1101; btn_load = 0; datos_ready = 0;
    repeat (12) tick();
    x0 = dut_xfers;
    btn_load = 1;
    for (int i = 0; i < 30 && !datos_valid; i++) tick();
    total++; if (datos_valid !== 1'b1) begin bad++; $display("FAIL capture_valid_timeout got=%b want=1", datos_valid); end
    total++; if (datos_in !== 4'b1101) begin bad++; $display("FAIL capture_word got=%h want=d", datos_in); end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (datos_valid !== 1'b1 || datos_in !== 4'b1101) begin
        bad++; $display("FAIL capture_hold cyc=%0d got=%b/%h want=1/d", i, datos_valid, datos_in);
      end
    end
    datos_ready = 1;
    tick();
    datos_ready = 0;
    total++; if (datos_valid !== 1'b0) begin bad++; $display("FAIL capture_valid_fall got=%b want=0", datos_valid); end
    total++; if (dut_xfers != x0 + 1 || last_word !== 4'b1101) begin
      bad++; $display("FAIL capture_xfer got=%0d/%h want=%0d/d", dut_xfers - x0, last_word, 1);
    end
  endtask

  task automatic test_held_button();
    int x0;
    x0 = dut_xfers - 1;
    datos_ready = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      total++; if (datos_valid !== 1'b0) begin bad++; $display("FAIL held_recapture cyc=%0d got=%b want=0", i, datos_valid); end
    end
    total++; if (dut_xfers != x0 + 1) begin bad++; $display("FAIL held_count got=%0d want=1", dut_xfers - x0); end
    datos_ready = 0; btn_load = 0;
    repeat (12) tick();
    sw = 4'b0011;
    repeat (12) tick();
    btn_load = 1;
    for (int i = 0; i < 30 && !datos_valid; i++) tick();
    total++; if (datos_valid !== 1'b1 || datos_in !== 4'b0011) begin
      bad++; $display("FAIL held_second_capture got=%b/%h want=1/3", datos_valid, datos_in);
    end
    datos_ready = 1;
    tick();
    datos_ready = 0;
    total++; if (dut_xfers != x0 + 2 || last_word !== 4'b0011) begin
      bad++; $display("FAIL held_second_xfer got=%0d/%h want=2/3", dut_xfers - x0, last_word);
    end
  endtask

  task automatic test_ready_early();
    int x0;
    btn_load = 0; sw = 4'b1001; datos_ready = 1;
    repeat (12) tick();
    x0 = dut_xfers;
    btn_load = 1;
    for (int i = 0; i < 30 && !datos_valid; i++) tick();
    total++; if (datos_valid !== 1'b1 || datos_in !== 4'b1001) begin
      bad++; $display("FAIL early_capture got=%b/%h want=1/9", datos_valid, datos_in);
    end
    sw = 4'b1111;
    tick();
    total++; if (datos_valid !== 1'b0) begin bad++; $display("FAIL early_one_cycle got=%b want=0", datos_valid); end
    total++; if (dut_xfers != x0 + 1 || last_word !== 4'b1001) begin
      bad++; $display("FAIL early_xfer got=%0d/%h want=1/9", dut_xfers - x0, last_word);
    end
    repeat (12) tick();
    total++; if (sw_vivo !== 4'b1111 || datos_in !== 4'b1001) begin
      bad++; $display("FAIL early_track got=%h/%h want=f/9", sw_vivo, datos_in);
    end
    datos_ready = 0;
  endtask

  task automatic test_mid_reset();
    int x0;
    btn_load = 0; datos_ready = 0;
    repeat (12) tick();
    btn_load = 1;
    for (int i = 0; i < 30 && !datos_valid; i++) tick();
    total++; if (datos_valid !== 1'b1) begin bad++; $display("FAIL midrst_enter got=%b want=1", datos_valid); end
    rst_n = 0; btn_load = 0;
    tick();
    total++; if (datos_valid !== 1'b0 || datos_in !== 4'h0) begin
      bad++; $display("FAIL midrst_drop got=%b/%h want=0/0", datos_valid, datos_in);
    end
    rst_n = 1;
    x0 = dut_xfers;
    datos_ready = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      total++; if (datos_valid !== 1'b0) begin bad++; $display("FAIL midrst_quiet cyc=%0d got=%b want=0", i, datos_valid); end
    end
    total++; if (dut_xfers != x0) begin bad++; $display("FAIL midrst_noxfer got=%0d want=0", dut_xfers - x0); end
    datos_ready = 0;
    btn_load = 1;
    for (int i = 0; i < 30 && !datos_valid; i++) tick();
    total++; if (datos_valid !== 1'b1 || datos_in !== 4'b1111) begin
      bad++; $display("FAIL midrst_new_press got=%b/%h want=1/f", datos_valid, datos_in);
    end
    datos_ready = 1;
    tick();
    datos_ready = 0; btn_load = 0;
    total++; if (dut_xfers != x0 + 1) begin bad++; $display("FAIL midrst_xfer got=%0d want=1", dut_xfers - x0); end
  endtask

  task automatic test_random();
    int hold, x_dut, x_mod;
    x_dut = dut_xfers; x_mod = m_xfers;
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 12);
        if ($urandom_range(0, 2) == 0) sw = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) btn_load = ~btn_load;
      end
      hold--;
      datos_ready = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
      rst_n = 1;
      total++;
      if (datos_valid !== m_valid || datos_in !== m_word || sw_vivo !== m_sw_stable) begin
        bad++;
        $display("FAIL random cyc=%0d got v=%b d=%h s=%h want v=%b d=%h s=%h",
                 c, datos_valid, datos_in, sw_vivo, m_valid, m_word, m_sw_stable);
      end
    end
    total++;
    if (dut_xfers - x_dut != m_xfers - x_mod) begin
      bad++; $display("FAIL random_xfer_count got=%0d want=%0d", dut_xfers - x_dut, m_xfers - x_mod);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_capture();
    test_held_button();
    test_ready_early();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_module_switches

// File: doc/module_switches.md
# module_switches

Input-side counterpart of the LED output block. It samples the 4-bit DIP-switch word and a load push-button, both asynchronous, with a two-flop synchronizer, and debounces them. On a debounced press it presents the stable switch word to the Hamming encoder path through a valid/ready handshake. A live debounced copy of the switches is also exported for display.

## Interface
- `DEBOUNCE_CYCLES`, default 270000: consecutive stable clocks required before a new input value is accepted (10 ms at 27 MHz); must be ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `sw`  in  4  raw DIP switches, asynchronous.
- `btn_load`  in  1  raw load button, asynchronous, active-high.
- `datos_in`  out  4  captured word for the encoder; stable while `datos_valid` is high.
- `datos_valid`  out  1  captured word available.
- `datos_ready`  in  1  consumer accepts; a transfer occurs on a clock edge with `datos_valid && datos_ready`.
- `sw_vivo`  out  4  live debounced switch value.

## Operation
- **Synchronizer:** two flip-flops on each of `sw[3:0]` and `btn_load`, all reset to 0.
- **Debouncer (per input group):** registers `cand`, `cnt` and `stable`.
  - If sync ≠ `cand`: `cand` ← sync, `cnt` ← 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable` ← `cand`, and `cnt` holds (saturates).
  - Else: `cnt` ← `cnt` + 1.
  - The switches are debounced as one 4-bit vector: any bit change restarts the count. The button is debounced separately.
- `sw_vivo` = switch `stable`.
- **FSM states:** IDLE, VALID, RELEASE.
  - IDLE: if `btn_stable == 1` → VALID and `datos_in` ← `sw_vivo`.
  - VALID: `datos_valid = 1`. If `datos_ready` → RELEASE.
  - RELEASE: wait for `btn_stable == 0` → IDLE.
  - Result: one capture per press. A held button never re-captures.
- Switch changes during VALID do not alter `datos_in`. `sw_vivo` keeps tracking.
- Button activity during VALID or RELEASE, other than release, is ignored.

## Timing
- Reset values: `datos_in = 0`, `datos_valid = 0`, `sw_vivo = 0`, FSM = IDLE, all counters and `cand` = 0. Reset applies on any edge with `rst_n = 0`, including mid-handshake. `datos_valid` drops on that edge and the pending word is discarded.
- **Input latency:** a raw input change that is stable before edge 1 appears on `stable` after edge `DEBOUNCE_CYCLES + 3`.
- A glitch shorter than `DEBOUNCE_CYCLES + 1` synchronized cycles never reaches `stable`.
- **Capture:** `btn_stable` rises after edge N; `datos_valid` and `datos_in` update after edge N+1.
- `datos_valid` is registered and falls the edge after the transfer.
- `datos_ready` may be high before `datos_valid`. Transfer then completes one cycle after `datos_valid` rises.
- If `btn_stable` and the switch `stable` update on the same edge, the capture in IDLE on the next edge uses the updated `sw_vivo`.
- A release observed in VALID, before the transfer, is not remembered. The RELEASE state then exits on its first cycle.

## Structure
- **Package `module_switches_pkg`:** `typedef enum logic [1:0] {IDLE, VALID, RELEASE} estado_t`, plus constant `DEBOUNCE_DEFAULT = 270000`.
- **Sub-module `module_debounce`:** parameters `W` and `DEBOUNCE_CYCLES`; contains the synchronizer, `cand`, `cnt` and `stable`.
  - Instantiated twice: `W = 4` for the switches, `W = 1` for the button.
- The top level holds the FSM and the output registers.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES = 4`.
1. **Reset:** `rst_n = 0` for 3 clocks with `sw = 4'b1010` → `datos_in = 0`, `datos_valid = 0`, `sw_vivo = 0`. After release, `sw_vivo = 4'b1010` after exactly 7 edges.
2. **Glitch rejection:** `sw` 0000 → 0101 for 3 clocks → 0000 → `sw_vivo` stays 0000 throughout.
3. **Capture/handshake:** `sw = 4'b1101` stable, press `btn_load` with `datos_ready = 0` → `datos_valid` high with `datos_in = 4'b1101`, held 20 cycles. Assert ready for 1 cycle → valid falls the next edge.
4. **Held button:** keep `btn_load` high for 50 cycles after the transfer → exactly one transfer. Release, then press again with `sw = 4'b0011` → second transfer of 0011.
5. **Ready pre-asserted, switch change during VALID:** `datos_ready = 1` constant, `sw` changes to 1111 while VALID → transferred word equals the word captured at press.
6. **Mid-handshake reset:** reset while in VALID → `datos_valid` low the next edge. No transfer until a new press after `btn_stable` returns to 0.
